add6_operand_seq: RTL and testbench



---
 rtl/add6_pkg.sv | 18 +
 rtl/add6_operand_seq_if.sv | 23 ++
 rtl/add6_op_regfile.sv | 30 +++
 rtl/add6_operand_seq.sv | 109 ++++++++++
 tb/tb_add6_operand_seq.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/add6_pkg.sv
// Shared constants and types for the six-operand adder sequencer.
package add6_pkg;

   localparam int OP_W    = 4;
   localparam int NUM_OPS = 6;
   localparam int SUM_W   = 6;
   localparam int CNT_W   = 8;

   typedef enum logic {
      FILL    = 1'b0,
      CAPTURE = 1'b1
   } state_e;

   typedef logic [2:0] idx_t;

   localparam idx_t LAST_IDX = idx_t'(NUM_OPS - 1);

endpackage

// File: rtl/add6_operand_seq_if.sv
// Operand stream in, frame-sum stream out; slave is the sequencer side.
interface add6_operand_seq_if;
   import add6_pkg::*;

   logic             in_valid;
   logic             in_ready;
   logic [OP_W-1:0]  in_data;
   logic             frame_clr;
   logic             out_valid;
   logic             out_ready;
   logic [SUM_W-1:0] out_sum;

   modport slave (
      input  in_valid, in_data, frame_clr, out_ready,
      output in_ready, out_valid, out_sum
   );

   modport master (
      output in_valid, in_data, frame_clr, out_ready,
      input  in_ready, out_valid, out_sum
   );

endinterface

// File: rtl/add6_op_regfile.sv
// Six-entry operand bank, one indexed write per cycle, all entries read in parallel.
// Write lands on the next edge; no backpressure, the caller gates wr_en_i.
module add6_op_regfile
   import add6_pkg::*;
(
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          wr_en_i,
   input  idx_t                          wr_idx_i,
   input  logic [OP_W-1:0]               wr_dat_i,
   output logic [NUM_OPS-1:0][OP_W-1:0]  ops_o
);

   logic [NUM_OPS-1:0][OP_W-1:0] ops_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ops_q <= '0;
      end else begin
         for (int i = 0; i < NUM_OPS; i++) begin
            if (wr_en_i && (wr_idx_i == idx_t'(i))) begin
               ops_q[i] <= wr_dat_i;
            end
         end
      end
   end

   assign ops_o = ops_q;

endmodule

// File: rtl/add6_operand_seq.sv
// Groups six serial operands into a frame for the external adder and registers its sum.
// Sum valid two cycles after the sixth beat; a held output stalls the block in CAPTURE.
module add6_operand_seq
   import add6_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   add6_operand_seq_if.slave io,
   output logic [OP_W-1:0]  op_a,
   output logic [OP_W-1:0]  op_b,
   output logic [OP_W-1:0]  op_c,
   output logic [OP_W-1:0]  op_d,
   output logic [OP_W-1:0]  op_e,
   output logic [OP_W-1:0]  op_f,
   input  logic [SUM_W-1:0] sum_in,
   output logic             busy,
   output logic [CNT_W-1:0] frame_cnt
);

   state_e                       state_q, state_d;
   idx_t                         idx_q, idx_d;
   logic                         out_valid_q, out_valid_d;
   logic [SUM_W-1:0]             out_sum_q, out_sum_d;
   logic [CNT_W-1:0]             cnt_q, cnt_d;
   logic                         in_rdy;
   logic                         wr_en;
   logic [NUM_OPS-1:0][OP_W-1:0] ops;

   add6_op_regfile u_regfile (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en_i  (wr_en),
      .wr_idx_i (idx_q),
      .wr_dat_i (io.in_data),
      .ops_o    (ops)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= FILL;
         idx_q       <= '0;
         out_valid_q <= 1'b0;
         out_sum_q   <= '0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         out_valid_q <= out_valid_d;
         out_sum_q   <= out_sum_d;
         cnt_q       <= cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      in_rdy      = 1'b0;
      wr_en       = 1'b0;
      out_valid_d = out_valid_q;
      out_sum_d   = out_sum_q;
      cnt_d       = cnt_q;

      if (out_valid_q && io.out_ready) begin
         out_valid_d = 1'b0;
      end

      case (state_q)
         FILL: begin
            // An abort wins over a beat presented on the same edge.
            in_rdy = !io.frame_clr;
            if (io.frame_clr) begin
               idx_d = '0;
            end else if (io.in_valid) begin
               wr_en = 1'b1;
               if (idx_q == LAST_IDX) begin
                  idx_d   = '0;
                  state_d = CAPTURE;
               end else begin
                  idx_d = idx_q + idx_t'(1);
               end
            end
         end
         CAPTURE: begin
            // Capture overrides the drain above, so accept+capture keeps valid high.
            if (!out_valid_q || io.out_ready) begin
               out_sum_d   = sum_in;
               out_valid_d = 1'b1;
               cnt_d       = cnt_q + CNT_W'(1);
               state_d     = FILL;
            end
         end
      endcase
   end

   assign io.in_ready  = in_rdy;
   assign io.out_valid = out_valid_q;
   assign io.out_sum   = out_sum_q;

   assign op_a = ops[0];
   assign op_b = ops[1];
   assign op_c = ops[2];
   assign op_d = ops[3];
   assign op_e = ops[4];
   assign op_f = ops[5];

   assign busy      = (idx_q != '0) || (state_q == CAPTURE);
   assign frame_cnt = cnt_q;

endmodule

// File: tb/tb_add6_operand_seq.sv
// Randomised and directed bench for the operand sequencer with an attached adder model.
module tb_add6_operand_seq;
   import add6_pkg::*;

   logic             clk;
   logic             rst_n;
   logic [OP_W-1:0]  op_a, op_b, op_c, op_d, op_e, op_f;
   logic [SUM_W-1:0] sum_in;
   logic             busy;
   logic [CNT_W-1:0] frame_cnt;

   logic             rand_ready;
   logic             rnd_rdy;
   logic             dir_rdy;

   int checks;
   int errors;

   logic [OP_W-1:0] acc_q[$];
   int              exp_sum_q[$];
   int              exp_cnt_q[$];
   int              frames_model;

   add6_operand_seq_if bus ();

   add6_operand_seq dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .io        (bus),
      .op_a      (op_a),
      .op_b      (op_b),
      .op_c      (op_c),
      .op_d      (op_d),
      .op_e      (op_e),
      .op_f      (op_f),
      .sum_in    (sum_in),
      .busy      (busy),
      .frame_cnt (frame_cnt)
   );

   // Adder: six operands zero-extended, result truncated to SUM_W bits.
   assign sum_in = {2'b00, op_a} + {2'b00, op_b} + {2'b00, op_c}
                 + {2'b00, op_d} + {2'b00, op_e} + {2'b00, op_f};

   assign bus.out_ready = rand_ready ? rnd_rdy : dir_rdy;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) begin
      #1;
      rnd_rdy = ($urandom_range(0, 3) != 0);
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_accept(input logic [OP_W-1:0] d);
      int s;
      acc_q.push_back(d);
      if (acc_q.size() == NUM_OPS) begin
         s = 0;
         foreach (acc_q[i]) s += int'(acc_q[i]);
         frames_model++;
         exp_sum_q.push_back(s % 64);
         exp_cnt_q.push_back(frames_model % 256);
         acc_q.delete();
      end
   endtask

   task automatic model_reset();
      acc_q.delete();
      exp_sum_q.delete();
      exp_cnt_q.delete();
      frames_model = 0;
   endtask

   // Called at posedge+1; returns at posedge+1 after the beat is taken.
   task automatic send_beat(input logic [OP_W-1:0] d);
      int n;
      bit ok;
      n  = 0;
      ok = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_data   = d;
      bus.frame_clr = 1'b0;
      while (!ok && n < 2000) begin
         @(negedge clk);
         if (bus.in_ready) ok = 1'b1;
         @(posedge clk);
         n++;
      end
      if (ok) model_accept(d);
      else chk("beat_accept_timeout", 0, 1);
      #1;
   endtask

   task automatic send_frame(input int v);
      for (int i = 0; i < NUM_OPS; i++) send_beat(OP_W'(v));
      bus.in_valid = 1'b0;
   endtask

   task automatic clr_beat(input logic [OP_W-1:0] d);
      bus.in_valid  = 1'b1;
      bus.in_data   = d;
      bus.frame_clr = 1'b1;
      @(negedge clk);
      chk("clr_in_ready", int'(bus.in_ready), 0);
      @(posedge clk);
      acc_q.delete();
      #1;
      bus.frame_clr = 1'b0;
      bus.in_valid  = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_sum_q.size() != 0 && n < 5000) begin
         @(posedge clk);
         n++;
      end
      #1;
      chk("drain_queue_empty", exp_sum_q.size(), 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_in_ready"},  int'(bus.in_ready), 1);
      chk({tag, "_out_valid"}, int'(bus.out_valid), 0);
      chk({tag, "_out_sum"},   int'(bus.out_sum), 0);
      chk({tag, "_frame_cnt"}, int'(frame_cnt), 0);
      chk({tag, "_busy"},      int'(busy), 0);
      chk({tag, "_ops"},       int'({op_a, op_b, op_c, op_d, op_e, op_f}), 0);
   endtask

   // Reset asserted mid-cycle, well away from either clock edge.
   task automatic pulse_reset(input string tag);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs(tag);
      model_reset();
      bus.in_valid  = 1'b0;
      bus.frame_clr = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (rst_n && bus.out_valid && bus.out_ready) begin
         if (exp_sum_q.size() == 0) begin
            chk("unexpected_output", 1, 0);
         end else begin
            chk("sb_out_sum",   int'(bus.out_sum), exp_sum_q.pop_front());
            chk("sb_frame_cnt", int'(frame_cnt),   exp_cnt_q.pop_front());
         end
      end
   end

   initial begin
      checks        = 0;
      errors        = 0;
      frames_model  = 0;
      rand_ready    = 1'b0;
      rnd_rdy       = 1'b0;
      dir_rdy       = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.frame_clr = 1'b0;
      rst_n         = 1'b0;

      #12;
      check_reset_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // First frame: latency and value.
      for (int i = 1; i <= NUM_OPS; i++) send_beat(OP_W'(i));
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("lat_t1_out_valid", int'(bus.out_valid), 0);
      chk("lat_t1_in_ready",  int'(bus.in_ready), 0);
      chk("lat_t1_busy",      int'(busy), 1);
      @(negedge clk);
      chk("lat_t2_out_valid", int'(bus.out_valid), 1);
      chk("lat_t2_out_sum",   int'(bus.out_sum), 21);
      chk("lat_t2_frame_cnt", int'(frame_cnt), 1);
      @(posedge clk);
      #1;

      send_frame(15);
      send_frame(0);
      drain();

      // Backpressure: second frame waits in CAPTURE behind the held sum.
      dir_rdy = 1'b0;
      for (int i = 1; i <= NUM_OPS; i++) send_beat(OP_W'(i));
      send_frame(2);
      repeat (3) @(negedge clk);
      chk("stall_in_ready",  int'(bus.in_ready), 0);
      chk("stall_busy",      int'(busy), 1);
      chk("stall_out_valid", int'(bus.out_valid), 1);
      chk("stall_out_sum",   int'(bus.out_sum), 21);
      chk("stall_ops", int'({op_a, op_b, op_c, op_d, op_e, op_f}), int'(24'h222222));
      @(posedge clk);
      #1;
      dir_rdy = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("nobubble_out_valid", int'(bus.out_valid), 1);
      chk("nobubble_out_sum",   int'(bus.out_sum), 12);
      @(posedge clk);
      #1;
      drain();

      // Abort after three beats drops the concurrent beat.
      send_beat(4'd7);
      send_beat(4'd7);
      send_beat(4'd7);
      clr_beat(4'd9);
      send_frame(1);

      // Abort on the sixth beat: no capture follows.
      for (int i = 0; i < 5; i++) send_beat(4'd3);
      clr_beat(4'd3);
      @(negedge clk);
      chk("clr6_busy", int'(busy), 0);
      @(negedge clk);
      chk("clr6_no_capture", int'(busy), 0);
      @(posedge clk);
      #1;
      send_frame(5);
      drain();

      // Random traffic; frame count crosses 255 -> 0.
      rand_ready = 1'b1;
      for (int f = 0; f < 500; f++) begin
         for (int b = 0; b < NUM_OPS; b++) begin
            if ($urandom_range(0, 2) == 0) begin
               bus.in_valid = 1'b0;
               repeat ($urandom_range(1, 3)) @(posedge clk);
               #1;
            end
            send_beat(OP_W'($urandom_range(0, 15)));
         end
      end
      bus.in_valid = 1'b0;
      rand_ready   = 1'b0;
      dir_rdy      = 1'b1;
      drain();

      // Reset in the middle of the fourth beat.
      send_beat(4'd1);
      send_beat(4'd2);
      send_beat(4'd3);
      bus.in_valid = 1'b1;
      bus.in_data  = 4'd4;
      pulse_reset("rst_beat4");
      send_frame(3);
      drain();

      // Reset while stalled in CAPTURE with a sum pending.
      dir_rdy = 1'b0;
      send_frame(9);
      send_frame(8);
      repeat (2) @(posedge clk);
      #1;
      pulse_reset("rst_capture");
      dir_rdy = 1'b1;
      send_frame(4);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
